// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - shared RISC16 constants and program loader state encoding
// Instruction memory geometry is shared between the core and the loader.
package risc16_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;
  localparam int IMEM_DATA_W = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_RUN   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader for the RISC16 instruction memory
// Define LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and the sticky error flag.
module prog_loader
  import risc16_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         ADDR_W    = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              iwr_en,
  output logic [ADDR_W-1:0] iwr_addr,
  output logic [15:0]       iwr_data,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic              r_in_ready;
  logic              r_iwr_en;
  logic [ADDR_W-1:0] r_iwr_addr;
  logic [15:0]       r_iwr_data;
  logic              r_cpu_run;
  logic              r_done;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_left;

  logic w_fire;
  logic w_is_sync;
  logic w_last;
  logic w_start;
  logic w_wr;
  logic w_finish;

  assign w_fire    = in_valid && r_in_ready;
  assign w_is_sync = (in_data == SYNC_BYTE);
  assign w_last    = (r_left == CNT_W'(1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_error;
  logic       w_csum_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_wr     = 1'b0;
    w_finish = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_csum_bad = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fire && w_is_sync) begin
          w_next  = ST_COUNT;
          w_start = 1'b1;
        end
      end
      ST_COUNT: begin
        if (w_fire) w_next = ST_HI;
      end
      ST_HI: begin
        if (w_fire) w_next = ST_LO;
      end
      ST_LO: begin
        if (w_fire) begin
          w_wr = 1'b1;
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = ST_CSUM;
`else
            w_next   = ST_RUN;
            w_finish = 1'b1;
`endif
          end else begin
            w_next = ST_HI;
          end
        end
      end
      ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_fire) begin
          if (in_data == r_csum) begin
            w_next   = ST_RUN;
            w_finish = 1'b1;
          end else begin
            w_next     = ST_IDLE;
            w_csum_bad = 1'b1;
          end
        end
`else
        w_next = ST_IDLE;
`endif
      end
      ST_RUN: begin
        // Only a fresh sync byte reloads; anything else is ignored while the core runs.
        if (w_fire && w_is_sync) begin
          w_next  = ST_COUNT;
          w_start = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_iwr_en   <= 1'b0;
      r_iwr_addr <= '0;
      r_iwr_data <= '0;
      r_cpu_run  <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_addr     <= '0;
      r_left     <= '0;
    end else begin
      r_in_ready <= 1'b1;
      r_iwr_en   <= w_wr;
      r_done     <= w_finish;
      if (w_start)       r_cpu_run <= 1'b0;
      else if (w_finish) r_cpu_run <= 1'b1;
      if (r_state == ST_COUNT && w_fire) begin
        r_addr <= '0;
        // A count of zero means a full memory image.
        r_left <= (in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(in_data);
      end
      if (r_state == ST_HI && w_fire) r_hi <= in_data;
      if (w_wr) begin
        r_iwr_addr <= r_addr;
        r_iwr_data <= {r_hi, in_data};
        r_addr     <= r_addr + 1'b1;
        r_left     <= r_left - 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_start) r_error <= 1'b0;
      else if (w_csum_bad) r_error <= 1'b1;
      if (r_state == ST_COUNT && w_fire) r_csum <= '0;
      else if ((r_state == ST_HI || r_state == ST_LO) && w_fire) r_csum <= r_csum ^ in_data;
    end
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign in_ready = r_in_ready;
  assign iwr_en   = r_iwr_en;
  assign iwr_addr = r_iwr_addr;
  assign iwr_data = r_iwr_data;
  assign cpu_run  = r_cpu_run;
  assign done     = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
// Frames carry a trailing checksum byte only when LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        iwr_en;
  logic [7:0]  iwr_addr;
  logic [15:0] iwr_data;
  logic        cpu_run;
  logic        done;
  logic        error;

  prog_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .iwr_en   (iwr_en),
    .iwr_addr (iwr_addr),
    .iwr_data (iwr_data),
    .cpu_run  (cpu_run),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int wr_cnt = 0;
  int addr0_cnt = 0;
  int ramp_err = 0;
  int base_wr;
  int base_a0;
  bit ramp_on = 1'b0;
  logic [7:0]  last_addr = 8'h00;
  logic [15:0] last_data = 16'h0000;

  always @(negedge clk) begin
    if (iwr_en === 1'b1) begin
      wr_cnt++;
      last_addr = iwr_addr;
      last_data = iwr_data;
      if (iwr_addr == 8'h00) addr0_cnt++;
      if (ramp_on && iwr_data !== {8'h00, iwr_addr}) ramp_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input logic [7:0] csum, input string tag);
`ifdef LOADER_CHECKSUM_EN
    send(csum);
`endif
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_run"}, {31'd0, cpu_run}, 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #20;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_iwr_en", {31'd0, iwr_en}, 32'd0);
    check("rst_iwr_addr", {24'd0, iwr_addr}, 32'd0);
    check("rst_iwr_data", {16'd0, iwr_data}, 32'd0);
    check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("ready_up", {31'd0, in_ready}, 32'd1);

    // Frame A: two words, checksum 12^34^AB^CD = 40
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
    check("a_w0_en", {31'd0, iwr_en}, 32'd1);
    check("a_w0_addr", {24'd0, iwr_addr}, 32'h00);
    check("a_w0_data", {16'd0, iwr_data}, 32'h1234);
    check("a_run_low", {31'd0, cpu_run}, 32'd0);
    send(8'hAB);
    check("a_gap_en", {31'd0, iwr_en}, 32'd0);
    send(8'hCD);
    check("a_w1_en", {31'd0, iwr_en}, 32'd1);
    check("a_w1_addr", {24'd0, iwr_addr}, 32'h01);
    check("a_w1_data", {16'd0, iwr_data}, 32'hABCD);
    finish_frame(8'h40, "a");
    idle(1);
    check("a_done_pulse", {31'd0, done}, 32'd0);
    check("a_run_held", {31'd0, cpu_run}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    send(8'hA5);
    check("bad_run_drop", {31'd0, cpu_run}, 32'd0);
    send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h00);
    check("bad_error", {31'd0, error}, 32'd1);
    check("bad_run", {31'd0, cpu_run}, 32'd0);
    check("bad_done", {31'd0, done}, 32'd0);
    send(8'hA5);
    check("resend_err_clr", {31'd0, error}, 32'd0);
    send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    finish_frame(8'h40, "resend");
`endif

    // Non-sync bytes in RUN are ignored
    idle(1);
    base_wr = wr_cnt;
    send(8'h00); send(8'hFF); send(8'h37);
    idle(2);
    check("run_ignore_wr", wr_cnt - base_wr, 32'd0);
    check("run_ignore_run", {31'd0, cpu_run}, 32'd1);

    // Reload while running: A5 01 00 07
    send(8'hA5);
    check("reload_run_drop", {31'd0, cpu_run}, 32'd0);
    send(8'h01); send(8'h00); send(8'h07);
    check("reload_addr", {24'd0, iwr_addr}, 32'h00);
    check("reload_data", {16'd0, iwr_data}, 32'h0007);
    finish_frame(8'h07, "reload");

    // Reset after the high byte of word 1
    send(8'hA5); send(8'h02); send(8'hDE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_data", {16'd0, iwr_data}, 32'd0);
    check("mid_rst_run", {31'd0, cpu_run}, 32'd0);
    base_wr = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(8'hAD);
    idle(2);
    check("mid_rst_nowr", wr_cnt - base_wr, 32'd0);

    // Leading garbage in IDLE, then frame A5 01 BE EF (checksum 51)
    base_wr = wr_cnt;
    send(8'h00); send(8'hFF); send(8'h37);
    idle(2);
    check("garbage_nowr", wr_cnt - base_wr, 32'd0);
    send(8'hA5); send(8'h01); send(8'hBE); send(8'hEF);
    check("g_addr", {24'd0, iwr_addr}, 32'h00);
    check("g_data", {16'd0, iwr_data}, 32'hBEEF);
    finish_frame(8'h51, "g");

    // N=0: 256 ascending words, XOR of all payload bytes is 00
    idle(2);
    base_wr = wr_cnt;
    base_a0 = addr0_cnt;
    ramp_on = 1'b1;
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'h00);
      send(8'(i));
    end
    finish_frame(8'h00, "full");
    idle(2);
    ramp_on = 1'b0;
    check("full_count", wr_cnt - base_wr, 32'd256);
    check("full_last_addr", {24'd0, last_addr}, 32'hFF);
    check("full_last_data", {16'd0, last_data}, 32'h00FF);
    check("full_addr0_once", addr0_cnt - base_a0, 32'd1);
    check("full_ramp", ramp_err, 32'd0);
    check("full_error", {31'd0, error}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
